hosted_sys_arbiter: RTL and testbench

Transaction-level round-robin arbiter that shares the single system memory port among the hosted requesters: host data, host instruction and NPU memory. It grants one requester at a time and holds the grant across address, data and (for writes) response phases. It also checks that beat counts match the declared burst length. It sits in front of the system crossbar and drives that crossbar's select lines from handshake pulses taken on the system side.

---
 rtl/hosted_arb_pkg.sv | 24 ++
 rtl/hosted_rr_pick.sv | 36 +++
 rtl/hosted_sys_arbiter.sv | 154 +++++++++++++++
 tb/tb_hosted_sys_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hosted_arb_pkg.sv
// Shared types and constants for the hosted system-port arbiter.
// Requester indices match the order of the packed requester buses.
package hosted_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam int REQ_HOST_DMEM = 0;
  localparam int REQ_HOST_IMEM = 1;
  localparam int REQ_NPU_MEM   = 2;

  localparam int DEF_N_REQ = 3;
  localparam int DEF_LEN_W = 8;

  // Index width that stays legal for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hosted_rr_pick.sv
// Combinational round-robin picker: the search starts just after last_id
// and wraps, so the most recent winner has the lowest priority.
module hosted_rr_pick
  import hosted_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic [N_REQ-1:0] pick,
  output logic [ID_W-1:0]  pick_id
);

  int unsigned     idx;
  logic [ID_W-1:0] sel;
  logic            found;

  always_comb begin
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_id) + k) % N_REQ;
      sel = ID_W'(idx);
      if (!found && req[sel]) begin
        found     = 1'b1;
        pick[sel] = 1'b1;
        pick_id   = sel;
      end
    end
  end

endmodule

// File: rtl/hosted_sys_arbiter.sv
// Transaction-level round-robin arbiter for the shared system memory port,
// holding the grant through address, data and write-response phases.
//
// state | meaning
// IDLE  | no transaction; pick a winner when any request is pending
// ADDR  | granted, waiting for AR/AW handshake; beats already counted
// DATA  | address done, counting R/W beats until beat_last
// RESP  | write data done, waiting for the B handshake
module hosted_sys_arbiter
  import hosted_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int LEN_W = DEF_LEN_W,
  localparam int ID_W = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   srst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_write,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic                   addr_accept,
  input  logic                   beat,
  input  logic                   beat_last,
  input  logic                   b_done,
  output logic [N_REQ-1:0]       grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   grant_write,
  output logic                   busy,
  output logic                   len_err
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             grant_write_q, grant_write_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             last_seen_q, last_seen_d;
  logic             len_err_q, len_err_d;

  logic [N_REQ-1:0] pick;
  logic [ID_W-1:0]  pick_id;
  logic             counting;
  logic             cnt_beat;
  logic             at_len;
  logic             beat_err;
  arb_state_e       done_state;

  hosted_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req     (req_valid),
    .last_id (last_id_q),
    .pick    (pick),
    .pick_id (pick_id)
  );

  // Write data may beat the AW handshake, so ADDR counts beats as well.
  assign counting   = (state_q == ADDR) || (state_q == DATA);
  assign cnt_beat   = counting && beat;
  assign at_len     = (beat_cnt_q == len_q);
  assign beat_err   = cnt_beat && (beat_last ? !at_len : at_len);
  assign done_state = grant_write_q ? RESP : IDLE;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_write_d = grant_write_q;
    last_id_d     = last_id_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    last_seen_d   = last_seen_q;
    len_err_d     = beat_err;

    if (cnt_beat) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d       = pick;
          grant_id_d    = pick_id;
          grant_write_d = req_write[pick_id];
          len_d         = req_len[int'(pick_id)*LEN_W +: LEN_W];
          beat_cnt_d    = '0;
          last_seen_d   = 1'b0;
          last_id_d     = pick_id;
          state_d       = ADDR;
        end
      end
      ADDR: begin
        if (addr_accept) begin
          if (last_seen_q || (beat && beat_last)) begin
            state_d = done_state;
          end else begin
            state_d = DATA;
          end
        end else if (beat && beat_last) begin
          last_seen_d = 1'b1;
        end
      end
      DATA: begin
        if (beat && beat_last) begin
          state_d = done_state;
        end
      end
      RESP: begin
        if (b_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (state_d == IDLE)) begin
      grant_d = '0;
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_write_q <= 1'b0;
      last_id_q     <= ID_W'(N_REQ - 1);
      len_q         <= '0;
      beat_cnt_q    <= '0;
      last_seen_q   <= 1'b0;
      len_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_write_q <= grant_write_d;
      last_id_q     <= last_id_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      last_seen_q   <= last_seen_d;
      len_err_q     <= len_err_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_write = grant_write_q;
  assign busy        = (state_q != IDLE);
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_hosted_sys_arbiter.sv
// Directed bench for hosted_sys_arbiter: reset, round-robin order, write
// lifecycle, early write data, length errors and asynchronous reset.
module tb_hosted_sys_arbiter;

  logic        clk;
  logic        srst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_write;
  logic [23:0] req_len;
  logic        addr_accept;
  logic        beat;
  logic        beat_last;
  logic        b_done;
  logic [2:0]  grant;
  logic [1:0]  grant_id;
  logic        grant_write;
  logic        busy;
  logic        len_err;

  int checks;
  int errors;

  hosted_sys_arbiter #(.N_REQ(3), .LEN_W(8)) dut (
    .clk         (clk),
    .srst_n      (srst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_len     (req_len),
    .addr_accept (addr_accept),
    .beat        (beat),
    .beat_last   (beat_last),
    .b_done      (b_done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_write (grant_write),
    .busy        (busy),
    .len_err     (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid   = '0;
    req_write   = '0;
    req_len     = '0;
    addr_accept = 1'b0;
    beat        = 1'b0;
    beat_last   = 1'b0;
    b_done      = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    srst_n = 1'b0;
    step();
    step();
    checks++;
    if ({grant, grant_id, grant_write, busy, len_err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b id=%0d wr=%b busy=%b err=%b required all zero",
               grant, grant_id, grant_write, busy, len_err);
    end
    #2 srst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_priority();
    logic [2:0] exp_order [4];
    exp_order[0] = 3'b001; exp_order[1] = 3'b010;
    exp_order[2] = 3'b100; exp_order[3] = 3'b001;
    req_valid = 3'b111;
    req_write = 3'b000;
    req_len   = '0;
    for (int t = 0; t < 4; t++) begin
      step();
      checks++;
      if (grant !== exp_order[t] || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant[%0d]: grant=%b busy=%b required grant=%b busy=1",
                 t, grant, busy, exp_order[t]);
      end
      addr_accept = 1'b1; beat = 1'b1; beat_last = 1'b1;
      step();
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0 || len_err !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap[%0d]: grant=%b busy=%b err=%b required 000/0/0",
                 t, grant, busy, len_err);
      end
      addr_accept = 1'b0; beat = 1'b0; beat_last = 1'b0;
      if (t == 3) req_valid = 3'b000;
    end
    step();
  endtask

  task automatic test_write_lifecycle();
    int bad;
    req_valid = 3'b100;
    req_write = 3'b100;
    req_len   = {8'd3, 8'd0, 8'd0};
    step();
    checks++;
    if (grant !== 3'b100 || grant_id !== 2'd2 || grant_write !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_grant: grant=%b id=%0d wr=%b busy=%b required 100/2/1/1",
               grant, grant_id, grant_write, busy);
    end
    req_valid = 3'b000;
    addr_accept = 1'b1;
    step();
    addr_accept = 1'b0;
    bad = 0;
    for (int b = 0; b < 4; b++) begin
      beat = 1'b1; beat_last = (b == 3);
      step();
      if (grant !== 3'b100 || grant_write !== 1'b1 || busy !== 1'b1 || len_err !== 1'b0) bad++;
    end
    beat = 1'b0; beat_last = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (grant !== 3'b100 || grant_write !== 1'b1 || busy !== 1'b1 || len_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wr_hold: %0d cycles lost grant/busy/direction or flagged len_err, required 0", bad);
    end
    b_done = 1'b1;
    checks++;
    if (grant !== 3'b100) begin
      errors++;
      $display("FAIL wr_bdone_cycle: grant=%b required 100", grant);
    end
    step();
    b_done = 1'b0;
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_release: grant=%b busy=%b required 000/0", grant, busy);
    end
  endtask

  task automatic test_write_data_first();
    req_valid = 3'b001;
    req_write = 3'b001;
    req_len   = {8'd0, 8'd0, 8'd1};
    step();
    checks++;
    if (grant !== 3'b001 || grant_write !== 1'b1) begin
      errors++;
      $display("FAIL wdf_grant: grant=%b wr=%b required 001/1", grant, grant_write);
    end
    req_valid = 3'b000;
    beat = 1'b1; beat_last = 1'b0;
    step();
    beat_last = 1'b1;
    step();
    beat = 1'b0; beat_last = 1'b0;
    checks++;
    if (busy !== 1'b1 || grant !== 3'b001 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL wdf_addr_wait: busy=%b grant=%b err=%b required 1/001/0", busy, grant, len_err);
    end
    addr_accept = 1'b1;
    step();
    addr_accept = 1'b0;
    checks++;
    if (busy !== 1'b1 || grant !== 3'b001 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL wdf_resp: busy=%b grant=%b err=%b required 1/001/0", busy, grant, len_err);
    end
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant !== 3'b000) begin
      errors++;
      $display("FAIL wdf_complete: busy=%b grant=%b required 0/000", busy, grant);
    end
  endtask

  task automatic test_len_err_early();
    req_valid = 3'b010;
    req_write = 3'b000;
    req_len   = {8'd0, 8'd3, 8'd0};
    step();
    checks++;
    if (grant !== 3'b010 || grant_id !== 2'd1 || grant_write !== 1'b0) begin
      errors++;
      $display("FAIL early_grant: grant=%b id=%0d wr=%b required 010/1/0", grant, grant_id, grant_write);
    end
    req_valid = 3'b000;
    addr_accept = 1'b1;
    step();
    addr_accept = 1'b0;
    beat = 1'b1; beat_last = 1'b0;
    step();
    checks++;
    if (len_err !== 1'b0 || grant !== 3'b010) begin
      errors++;
      $display("FAIL early_beat1: err=%b grant=%b required 0/010", len_err, grant);
    end
    beat_last = 1'b1;
    step();
    beat = 1'b0; beat_last = 1'b0;
    checks++;
    if (len_err !== 1'b1 || grant !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_beat2: err=%b grant=%b busy=%b required 1/000/0", len_err, grant, busy);
    end
    step();
    checks++;
    if (len_err !== 1'b0) begin
      errors++;
      $display("FAIL early_pulse_width: err=%b required 0", len_err);
    end
  endtask

  task automatic test_len_err_missing();
    req_valid = 3'b100;
    req_write = 3'b000;
    req_len   = {8'd1, 8'd0, 8'd0};
    step();
    checks++;
    if (grant !== 3'b100) begin
      errors++;
      $display("FAIL miss_grant: grant=%b required 100", grant);
    end
    req_valid = 3'b000;
    addr_accept = 1'b1;
    step();
    addr_accept = 1'b0;
    beat = 1'b1; beat_last = 1'b0;
    step();
    checks++;
    if (len_err !== 1'b0 || grant !== 3'b100) begin
      errors++;
      $display("FAIL miss_beat1: err=%b grant=%b required 0/100", len_err, grant);
    end
    step();
    checks++;
    if (len_err !== 1'b1 || grant !== 3'b100) begin
      errors++;
      $display("FAIL miss_beat2: err=%b grant=%b required 1/100", len_err, grant);
    end
    beat_last = 1'b1;
    step();
    beat = 1'b0; beat_last = 1'b0;
    // Third beat: count 2 against len 1 with last set is itself a mismatch.
    checks++;
    if (len_err !== 1'b1 || grant !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL miss_beat3: err=%b grant=%b busy=%b required 1/000/0", len_err, grant, busy);
    end
    step();
    checks++;
    if (len_err !== 1'b0) begin
      errors++;
      $display("FAIL miss_after: err=%b required 0", len_err);
    end
  endtask

  task automatic test_async_reset();
    req_valid = 3'b001;
    req_write = 3'b000;
    req_len   = {8'd0, 8'd0, 8'd3};
    step();
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL ar_grant: grant=%b required 001", grant);
    end
    req_valid = 3'b000;
    addr_accept = 1'b1;
    step();
    addr_accept = 1'b0;
    beat = 1'b1;
    step();
    beat = 1'b0;
    #2 srst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL ar_immediate: grant=%b busy=%b id=%0d required 000/0/0", grant, busy, grant_id);
    end
    step();
    #2 srst_n = 1'b1;
    req_valid = 3'b111;
    req_len   = '0;
    step();
    checks++;
    if (grant !== 3'b001 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL ar_first_winner: grant=%b id=%0d required 001/0", grant, grant_id);
    end
    req_valid = 3'b000;
    addr_accept = 1'b1; beat = 1'b1; beat_last = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (busy !== 1'b0 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL ar_finish: busy=%b err=%b required 0/0", busy, len_err);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    srst_n = 1'b0;
    test_reset();
    test_reset_priority();
    test_write_lifecycle();
    test_write_data_first();
    test_len_err_early();
    test_len_err_missing();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
